// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates EX/ID PC redirects into fetch, holds them across stalls, squashes and counts
module fetch_redirect_ctrl #(
  parameter int ADDR_WIDTH = 26,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_ex_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_redirect_pc,
  input  logic                  i_id_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_id_redirect_pc,
  output logic                  o_load_we,
  output logic [ADDR_WIDTH-1:0] o_load_pc,
  output logic                  o_flush_if,
  output logic                  o_flush_id,
  output logic                  o_pending,
  output logic [CNT_WIDTH-1:0]  o_redirect_count,
  output logic [CNT_WIDTH-1:0]  o_squash_count
);
  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;
  state_t state;
  logic [3:0] cnt;
  logic pend_src;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic hold, flush, id_take, squash, cand_v, cand_src, issue;
  logic [ADDR_WIDTH-1:0] cand_pc;
  // An ID request is only usable in IDLE, or in HOLD when it replaces an older ID entry
  always_comb begin
    hold = state == HOLD;
    flush = state == FLUSH;
    id_take = i_id_redirect_valid & ~i_ex_redirect_valid & (state == IDLE | (hold & ~pend_src));
    squash = i_id_redirect_valid & ~id_take;
    cand_v = i_ex_redirect_valid | id_take | hold;
    cand_src = i_ex_redirect_valid | (~id_take & pend_src);
    cand_pc = i_ex_redirect_valid ? i_ex_redirect_pc : id_take ? i_id_redirect_pc : pend_pc;
    issue = rst_n & cand_v & ~i_stall;
  end
  assign o_load_we = issue;
  assign o_load_pc = issue ? cand_pc : '0;
  assign o_flush_if = issue | (rst_n & flush);
  assign o_flush_id = issue & cand_src;
  assign o_pending = hold;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend_src <= 1'b0;
      pend_pc <= '0;
      o_redirect_count <= '0;
      o_squash_count <= '0;
    end else begin
      if (issue && o_redirect_count != '1) o_redirect_count <= o_redirect_count + 1'b1;
      if (squash && o_squash_count != '1) o_squash_count <= o_squash_count + 1'b1;
      if (issue) begin
        state <= FLUSH_CYCLES == 0 ? IDLE : FLUSH;
        cnt <= 4'(FLUSH_CYCLES);
        pend_src <= 1'b0;
        pend_pc <= '0;
      end else if (cand_v) begin
        state <= HOLD;
        pend_src <= cand_src;
        pend_pc <= cand_pc;
      end else if (flush && !i_stall) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed spec scenarios plus random traffic checked against a behavioural model
module tb_fetch_redirect_ctrl;
  localparam int AW = 26;
  localparam int FC = 1;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n, i_stall, i_ex_redirect_valid, i_id_redirect_valid;
  logic [AW-1:0] i_ex_redirect_pc, i_id_redirect_pc;
  logic o_load_we, o_flush_if, o_flush_id, o_pending;
  logic [AW-1:0] o_load_pc;
  logic [CW-1:0] o_redirect_count, o_squash_count;
  int errors = 0, checks = 0;
  logic m_pv, m_psrc;
  logic [AW-1:0] m_ppc;
  int m_fl, m_rc, m_sc;

  fetch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall),
    .i_ex_redirect_valid(i_ex_redirect_valid), .i_ex_redirect_pc(i_ex_redirect_pc),
    .i_id_redirect_valid(i_id_redirect_valid), .i_id_redirect_pc(i_id_redirect_pc),
    .o_load_we(o_load_we), .o_load_pc(o_load_pc), .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_pending(o_pending), .o_redirect_count(o_redirect_count), .o_squash_count(o_squash_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare every output with the model, then advance the model
  task automatic step(input logic r, input logic s, input logic ev, input logic [AW-1:0] ep,
                      input logic iv, input logic [AW-1:0] ip);
    logic e_we, e_fi, e_fid, have, esrc, sq;
    logic [AW-1:0] e_pc, epc;
    @(posedge clk);
    #1;
    rst_n = r; i_stall = s;
    i_ex_redirect_valid = ev; i_ex_redirect_pc = ep;
    i_id_redirect_valid = iv; i_id_redirect_pc = ip;
    @(negedge clk);
    e_we = 0; e_fi = 0; e_fid = 0; e_pc = '0; have = 0; esrc = 0; sq = 0; epc = '0;
    if (r) begin
      e_fi = m_fl > 0;
      if (m_pv) begin
        have = 1; epc = m_ppc; esrc = m_psrc;
        if (ev) begin sq = iv; epc = ep; esrc = 1; end
        else if (iv) begin
          if (!m_psrc) epc = ip;
          else sq = 1;
        end
      end else if (m_fl > 0) begin
        sq = iv;
        if (ev) begin have = 1; epc = ep; esrc = 1; end
      end else if (ev || iv) begin
        have = 1; sq = ev & iv; epc = ev ? ep : ip; esrc = ev;
      end
      if (have && !s) begin e_we = 1; e_pc = epc; e_fi = 1; e_fid = esrc; end
    end
    chk("load_we", 32'(o_load_we), 32'(e_we));
    chk("load_pc", 32'(o_load_pc), 32'(e_pc));
    chk("flush_if", 32'(o_flush_if), 32'(e_fi));
    chk("flush_id", 32'(o_flush_id), 32'(e_fid));
    chk("pending", 32'(o_pending), 32'(m_pv));
    chk("redirect_count", 32'(o_redirect_count), 32'(m_rc));
    chk("squash_count", 32'(o_squash_count), 32'(m_sc));
    if (!r) begin
      m_pv = 0; m_psrc = 0; m_ppc = '0; m_fl = 0; m_rc = 0; m_sc = 0;
    end else begin
      if (sq && m_sc < CMAX) m_sc++;
      if (e_we) begin
        if (m_rc < CMAX) m_rc++;
        m_pv = 0; m_fl = FC;
      end else if (have) begin
        m_pv = 1; m_ppc = epc; m_psrc = esrc; m_fl = 0;
      end else if (m_fl > 0 && !s) m_fl--;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, '0, 0, '0);
  endtask

  initial begin
    rst_n = 0; i_stall = 0; i_ex_redirect_valid = 0; i_id_redirect_valid = 0;
    i_ex_redirect_pc = '0; i_id_redirect_pc = '0;
    m_pv = 0; m_psrc = 0; m_ppc = '0; m_fl = 0; m_rc = 0; m_sc = 0;
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    // Reset while holding a redirect
    step(1, 1, 1, 26'h400, 0, '0);
    step(1, 1, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    idle();
    chk("t1_pending", 32'(o_pending), 32'd0);
    chk("t1_we", 32'(o_load_we), 32'd0);
    // ID redirect from IDLE
    step(1, 0, 0, '0, 1, 26'h100);
    chk("t2_we", 32'(o_load_we), 32'd1);
    chk("t2_pc", 32'(o_load_pc), 32'h100);
    chk("t2_fid", 32'(o_flush_id), 32'd0);
    idle();
    chk("t2_flush_tail", 32'(o_flush_if), 32'd1);
    idle();
    chk("t2_idle_fi", 32'(o_flush_if), 32'd0);
    chk("t2_rcount", 32'(o_redirect_count), 32'd1);
    // EX and ID together
    step(1, 0, 1, 26'h200, 1, 26'h300);
    chk("t3_pc", 32'(o_load_pc), 32'h200);
    chk("t3_fid", 32'(o_flush_id), 32'd1);
    idle();
    chk("t3_squash", 32'(o_squash_count), 32'd1);
    idle();
    // EX under stall, then ID arrives in HOLD and is discarded
    step(1, 1, 1, 26'h400, 0, '0);
    chk("t4_we0", 32'(o_load_we), 32'd0);
    step(1, 1, 0, '0, 0, '0);
    chk("t4_pend", 32'(o_pending), 32'd1);
    step(1, 1, 0, '0, 1, 26'h500);
    chk("t5_we0", 32'(o_load_we), 32'd0);
    step(1, 0, 0, '0, 0, '0);
    chk("t4_pc", 32'(o_load_pc), 32'h400);
    chk("t4_fid", 32'(o_flush_id), 32'd1);
    chk("t5_squash", 32'(o_squash_count), 32'd2);
    // Wrong-path ID in FLUSH, then EX reloads
    step(1, 0, 0, '0, 1, 26'h600);
    chk("t6_no_issue", 32'(o_load_we), 32'd0);
    step(1, 0, 1, 26'h700, 0, '0);
    chk("t6_ex_pc", 32'(o_load_pc), 32'h700);
    idle();
    chk("t6_reload_fi", 32'(o_flush_if), 32'd1);
    for (int i = 0; i < 40; i++) step(1, 0, 1, AW'($urandom), 0, '0);
    idle();
    chk("t6_sat", 32'(o_redirect_count), 32'(CMAX));
    step(0, 0, 0, '0, 0, '0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) != 0, $urandom_range(9) < 4, $urandom_range(3) == 0, AW'($urandom),
           $urandom_range(9) < 3, AW'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
